instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Sequential writer for the RISC-V core's instruction memory: accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instructions, and writes them to consecutive word addresses from 0. Sits between the board-side byte source (UART RX or testbench) and the instruction memory write port. It holds the core in reset while loading and optionally rejects words whose opcode the main decoder does not support.

## Interface
- ADDR_W, 9, instruction-memory word-address width; capacity 2**ADDR_W words
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  single-cycle pulse; begins a load session
- byte_valid  in  1  byte_data holds a valid byte
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  instruction-memory write strobe
- wr_addr  out  ADDR_W  word address being written
- wr_data  out  32  assembled instruction
- cpu_hold  out  1  keeps the core in reset while loading
- done  out  1  session completed successfully
- err  out  1  session aborted
- word_count  out  ADDR_W+1  words written in the current or last session

## Operation
- Stream format: 2-byte little-endian header N (word count), then N words of 4 bytes each, least-significant byte first.
- A byte transfers on a rising edge with byte_valid && byte_ready.
- States: IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR.
- IDLE: byte_ready=0. On start -> LEN0, cpu_hold=1, word_count=0, byte index=0, done=0, err=0.
- LEN0: accept low header byte -> LEN1. LEN1: accept high byte, latch N.
  - N==0 -> DONE. N > 2**ADDR_W -> ERR. Otherwise -> DATA.
- DATA: accept bytes into byte position 0..3; on the 4th accepted byte -> WRITE.
- WRITE: byte_ready=0, wr_en=1 for exactly one cycle, wr_addr=word_count[ADDR_W-1:0], wr_data=assembled word. Then word_count increments. Go to DONE if the new count equals N, else DATA.
- DONE: done=1, cpu_hold=0, byte_ready=0. On start, begin a new session as in IDLE.
- ERR: err=1, cpu_hold stays 1, byte_ready=0, no further writes. Only start or reset leaves ERR.
- start is ignored in LEN0, LEN1, DATA and WRITE.
- byte_valid arriving while byte_ready=0 is not consumed. The source must hold it.

## Timing
- Reset (reset==0 at a clock edge) forces state=IDLE and all outputs to 0: byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err, word_count.
- Reset mid-session aborts with no further writes. Words already written stay in memory.
- byte_ready is registered and derived from state only. It is high in LEN0, LEN1 and DATA.
- wr_en rises on the edge after the 4th data byte is accepted (1-cycle latency).
- Minimum throughput: 5 cycles per word (4 byte cycles + 1 WRITE cycle).
- done or err asserts on the edge leaving WRITE/LEN1.
- cpu_hold deasserts on the same edge that done asserts.
- word_count and wr_addr wrap never occurs: the header check guarantees N ≤ 2**ADDR_W.

## Configuration
- LOADER_OPCODE_CHECK_EN defined:
  - In WRITE, wr_data[6:0] is compared to the supported set: R-type 0110011, I-type 0010011, load 0000011, store 0100011, branch 1100011, jal 1101111, jalr 1100111.
  - On a mismatch, wr_en stays 0, the loader goes to ERR, and word_count is not incremented.
- LOADER_OPCODE_CHECK_EN undefined: every assembled word is written unconditionally, and ERR is reached only via the header check.

## Structure
- Shared package riscv_pkg holds:
  - the opcode localparams, shared with the main decoder
  - the loader state typedef enum (loader_state_t)
  - LOADER_HDR_BYTES=2 and LOADER_WORD_BYTES=4
- One sub-module, byte_assembler:
  - a 32-bit shift register with a 2-bit byte index, load-enable and clear
  - outputs the assembled word and a word_full flag

## Test plan
- Reset with byte_valid=1 -> all outputs 0, byte_ready=0. Then pulse start -> byte_ready=1, cpu_hold=1 on the next cycle.
- Header 02 00, then bytes 93 00 10 00 and 33 81 20 00 with continuous valid -> wr_en pulses twice: addr0=0x00100093, addr1=0x00208133. Then done=1, cpu_hold=0, word_count=2.
- Header 00 00 -> DONE directly, no wr_en pulse, word_count=0.
- Header 01 02 with ADDR_W=9 (N=513) -> err=1, cpu_hold=1, no writes, byte_ready=0.
- With LOADER_OPCODE_CHECK_EN: header 01 00, then bytes 7F 00 00 00 -> err=1, no write. Without the macro -> word 0x0000007F written at addr 0, done=1.
- Stall source (byte_valid low 3 cycles between bytes), then assert reset mid-word -> state returns to IDLE, partial word never written, outputs 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// =============================================================================
// Module      : riscv_pkg
// Description : Shared RISC-V definitions: base opcodes understood by the main
//               decoder, loader state encoding and loader stream constants.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package riscv_pkg;

  // Base opcodes supported by the main decoder
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Loader stream framing: 16-bit word-count header, 32-bit words
  localparam int LOADER_HDR_BYTES  = 2;
  localparam int LOADER_WORD_BYTES = 4;

  // Loader session states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } loader_state_t;

  // True when the opcode field belongs to the decoder's supported set
  function automatic logic opcode_supported(input logic [6:0] i_opc);
    logic v_ok;
    case (i_opc)
      OPC_RTYPE, OPC_ITYPE, OPC_LOAD, OPC_STORE,
      OPC_BRANCH, OPC_JAL, OPC_JALR: v_ok = 1'b1;
      default:                       v_ok = 1'b0;
    endcase
    return v_ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_assembler.sv
// =============================================================================
// Module      : byte_assembler
// Description : Collects four stream bytes, least-significant first, into a
//               32-bit word. o_full flags the cycle the last byte is loaded.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module byte_assembler
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,    // synchronous, active-low
  input  logic        i_clr,
  input  logic        i_load,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_full
);

  localparam logic [1:0] c_LAST_IDX = 2'(LOADER_WORD_BYTES - 1);

  logic [31:0] r_word;
  logic [1:0]  r_idx;

  // Shift each new byte in at the top so the first byte ends up in [7:0]
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_clr) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_word <= {i_byte, r_word[31:8]};
      r_idx  <= r_idx + 2'd1;
    end
  end

  assign o_word = r_word;
  assign o_full = i_load && (r_idx == c_LAST_IDX);

endmodule

`default_nettype wire

// File: rtl/instr_mem_loader.sv
// =============================================================================
// Module      : instr_mem_loader
// Description : Byte-stream loader for the instruction memory. Reads a 16-bit
//               little-endian word count, then that many little-endian words,
//               writing them to consecutive word addresses from 0 while the
//               core is held in reset.
//               Optional macro LOADER_OPCODE_CHECK_EN: reject (abort on) any
//               word whose opcode the main decoder does not support.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module instr_mem_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 9
)(
  input  logic              clk,
  input  logic              reset,       // synchronous, active-low
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [31:0]   c_CAPACITY = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] c_WC_ONE = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_t   r_state;
  loader_state_t   w_next;
  logic [7:0]      r_len_lo;
  logic [15:0]     r_len;
  logic [ADDR_W:0] r_word_count;
  logic            r_byte_ready;
  logic            r_cpu_hold;
  logic            r_done;
  logic            r_err;

  logic            w_xfer;
  logic            w_start_sess;
  logic [15:0]     w_hdr_len;
  logic [31:0]     w_word;
  logic            w_full;
  logic            w_opc_ok;
  logic            w_write;
  logic            w_last;

  assign w_xfer       = byte_valid && r_byte_ready;
  assign w_start_sess = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                  (r_state == ST_ERR));
  assign w_hdr_len    = {byte_data, r_len_lo};
  assign w_last       = ((32'(r_word_count) + 32'd1) == {16'd0, r_len});

`ifdef LOADER_OPCODE_CHECK_EN
  assign w_opc_ok = opcode_supported(w_word[6:0]);
`else
  assign w_opc_ok = 1'b1;
`endif

  assign w_write = (r_state == ST_WRITE) && w_opc_ok;

  byte_assembler u_asm (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_start_sess),
    .i_load (w_xfer && (r_state == ST_DATA)),
    .i_byte (byte_data),
    .o_word (w_word),
    .o_full (w_full)
  );

  // Next-state selection; start only matters in the resting states
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) w_next = ST_LEN0;
      ST_LEN0: if (w_xfer) w_next = ST_LEN1;
      ST_LEN1: begin
        if (w_xfer) begin
          if (w_hdr_len == 16'd0)                      w_next = ST_DONE;
          else if ({16'd0, w_hdr_len} > c_CAPACITY)    w_next = ST_ERR;
          else                                         w_next = ST_DATA;
        end
      end
      ST_DATA: if (w_full) w_next = ST_WRITE;
      ST_WRITE: begin
        if (!w_opc_ok)   w_next = ST_ERR;
        else if (w_last) w_next = ST_DONE;
        else             w_next = ST_DATA;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register plus flags registered from the state being entered
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_byte_ready <= 1'b0;
      r_cpu_hold   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_byte_ready <= (w_next == ST_LEN0) || (w_next == ST_LEN1) || (w_next == ST_DATA);
      r_cpu_hold   <= (w_next == ST_LEN0) || (w_next == ST_LEN1) || (w_next == ST_DATA) ||
                      (w_next == ST_WRITE) || (w_next == ST_ERR);
      r_done       <= (w_next == ST_DONE);
      r_err        <= (w_next == ST_ERR);
    end
  end

  // Header latch and written-word counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_len_lo     <= '0;
      r_len        <= '0;
      r_word_count <= '0;
    end else begin
      if ((r_state == ST_LEN0) && w_xfer) r_len_lo <= byte_data;
      if ((r_state == ST_LEN1) && w_xfer) r_len    <= w_hdr_len;
      if (w_start_sess)  r_word_count <= '0;
      else if (w_write)  r_word_count <= r_word_count + c_WC_ONE;
    end
  end

  assign byte_ready = r_byte_ready;
  assign wr_en      = w_write;
  assign wr_addr    = r_word_count[ADDR_W-1:0];
  assign wr_data    = w_word;
  assign cpu_hold   = r_cpu_hold;
  assign done       = r_done;
  assign err        = r_err;
  assign word_count = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// =============================================================================
// Module      : tb_instr_mem_loader
// Description : Self-checking bench for instr_mem_loader. A stream-level model
//               predicts the writes and final status of each session.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_instr_mem_loader;

  localparam int ADDR_W = 9;
  localparam int CAP    = 1 << ADDR_W;

`ifdef LOADER_OPCODE_CHECK_EN
  localparam bit c_CHECK = 1'b1;
`else
  localparam bit c_CHECK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] mon_addr[$];
  logic [31:0]       mon_data[$];

  always #5 clk = ~clk;

  instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  // Record every write strobe seen by the memory
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      mon_addr.push_back(wr_addr);
      mon_data.push_back(wr_data);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit opc_known(input logic [6:0] opc);
    logic [6:0] known[7];
    known = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
    foreach (known[i]) if (known[i] == opc) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ready"}, 64'(byte_ready), 64'd0);
    check_val({tag, "_wren"},  64'(wr_en),      64'd0);
    check_val({tag, "_waddr"}, 64'(wr_addr),    64'd0);
    check_val({tag, "_wdata"}, 64'(wr_data),    64'd0);
    check_val({tag, "_hold"},  64'(cpu_hold),   64'd0);
    check_val({tag, "_done"},  64'(done),       64'd0);
    check_val({tag, "_err"},   64'(err),        64'd0);
    check_val({tag, "_wcnt"},  64'(word_count), 64'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Offer bytes s[0..cnt-1] one at a time, with random idle gaps up to max_gap
  task automatic drive_bytes(input logic [7:0] s[$], input int cnt, input int max_gap,
                             input string tag);
    int waited;
    for (int k = 0; k < cnt; k++) begin
      if (max_gap > 0) begin
        byte_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = s[k];
      waited = 0;
      while (byte_ready !== 1'b1 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (byte_ready !== 1'b1) begin
        check_val({tag, "_ready_timeout"}, 64'(byte_ready), 64'd1);
        byte_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  // Run one full session and compare against the stream-level prediction
  task automatic run_session(input logic [7:0] s[$], input int max_gap, input string tag);
    int               n;
    int               n_accept;
    int               waited;
    bit               exp_err;
    logic [31:0]      w;
    logic [ADDR_W-1:0] e_addr[$];
    logic [31:0]      e_data[$];

    n        = int'({s[1], s[0]});
    n_accept = 2;
    exp_err  = 1'b0;
    if (n > CAP) exp_err = 1'b1;
    else begin
      for (int i = 0; i < n; i++) begin
        w = {s[2 + 4*i + 3], s[2 + 4*i + 2], s[2 + 4*i + 1], s[2 + 4*i]};
        n_accept += 4;
        if (c_CHECK && !opc_known(w[6:0])) begin
          exp_err = 1'b1;
          break;
        end
        e_addr.push_back(ADDR_W'(i));
        e_data.push_back(w);
      end
    end

    mon_addr.delete();
    mon_data.delete();
    pulse_start();
    drive_bytes(s, n_accept, max_gap, tag);

    waited = 0;
    while (done !== 1'b1 && err !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);

    check_val({tag, "_nwrites"}, 64'(mon_addr.size()), 64'(e_addr.size()));
    for (int i = 0; i < e_addr.size() && i < mon_addr.size(); i++) begin
      check_val($sformatf("%s_addr%0d", tag, i), 64'(mon_addr[i]), 64'(e_addr[i]));
      check_val($sformatf("%s_data%0d", tag, i), 64'(mon_data[i]), 64'(e_data[i]));
    end
    check_val({tag, "_done"},  64'(done),       64'(!exp_err));
    check_val({tag, "_err"},   64'(err),        64'(exp_err));
    check_val({tag, "_hold"},  64'(cpu_hold),   64'(exp_err));
    check_val({tag, "_ready"}, 64'(byte_ready), 64'd0);
    check_val({tag, "_wcnt"},  64'(word_count), 64'(e_addr.size()));
  endtask

  initial begin
    logic [7:0] s[$];
    logic [31:0] r;
    logic [6:0]  opc;
    logic [6:0]  opc_list[7];
    int          n;

    opc_list = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};

    // Reset with a valid byte pending and a start pulse that must be ignored
    reset = 1'b0; byte_valid = 1'b1; byte_data = 8'hA5;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_all_zero("rst");
    reset = 1'b1; byte_valid = 1'b0;
    @(negedge clk);
    check_val("idle_ready", 64'(byte_ready), 64'd0);
    pulse_start();
    check_val("start_ready", 64'(byte_ready), 64'd1);
    check_val("start_hold",  64'(cpu_hold),   64'd1);
    check_val("start_done",  64'(done),       64'd0);

    // Two-word program with continuous valid (start is re-pulsed in LEN0)
    s = {8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h33, 8'h81, 8'h20, 8'h00};
    run_session(s, 0, "two");

    // Empty program
    s = {8'h00, 8'h00};
    run_session(s, 0, "empty");

    // Header just above capacity
    s = {8'h01, 8'h02};
    run_session(s, 0, "oversize");

    // Unsupported opcode word
    s = {8'h01, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00};
    run_session(s, 0, "badopc");

    // Randomized programs, some with stalls and unsupported opcodes
    for (int t = 0; t < 8; t++) begin
      s.delete();
      n = $urandom_range(1, 6);
      s.push_back(8'(n));
      s.push_back(8'h00);
      for (int i = 0; i < n; i++) begin
        r = $urandom();
        if ($urandom_range(0, 4) != 0) opc = opc_list[$urandom_range(0, 6)];
        else                           opc = r[6:0] ^ 7'h55;
        r = {r[31:7], opc};
        for (int b = 0; b < 4; b++) s.push_back(r[8*b +: 8]);
      end
      run_session(s, (t % 2) * 3, $sformatf("rnd%0d", t));
    end

    // Stalled stream interrupted by reset in the middle of a word
    mon_addr.delete();
    mon_data.delete();
    s = {8'h02, 8'h00, 8'h93, 8'h00};
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      s.delete();
      s.push_back(k == 0 ? 8'h02 : (k == 1 ? 8'h00 : (k == 2 ? 8'h93 : 8'h00)));
      byte_valid = 1'b0;
      repeat (3) @(negedge clk);
      drive_bytes(s, 1, 0, "midrst");
    end
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("midrst_nwrites", 64'(mon_addr.size()), 64'd0);
    check_val("midrst_idle_ready", 64'(byte_ready), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
